// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic result stage: flag bit positions,
// the flag vector type, the output buffer state encoding and the width of
// the optional error counter.
package arith_pkg;

    localparam int FLAG_E    = 3;
    localparam int FLAG_V    = 2;
    localparam int FLAG_N    = 1;
    localparam int FLAG_Z    = 0;
    localparam int ERR_CNT_W = 8;

    typedef logic [3:0] flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/arith_flag_gen.sv
// Capture-side sanitisation and status flag derivation. A result that comes
// with an error or overflow bit may be undefined, so it is forced to zero
// before it is stored; the flags are then derived from the sanitised value.
module arith_flag_gen
    import arith_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] result_i,
    input  logic            error_i,
    input  logic            overflow_i,
    output logic [BITS-1:0] result_o,
    output flags_t          flags_o
);

    logic bad;

    // Zero the result on error/overflow and build {E,V,N,Z}; E and V are
    // reported independently, with no priority between them.
    always_comb begin
        bad              = error_i | overflow_i;
        result_o         = bad ? '0 : result_i;
        flags_o          = '0;
        flags_o[FLAG_E]  = error_i;
        flags_o[FLAG_V]  = overflow_i;
        flags_o[FLAG_N]  = result_o[BITS-1];
        flags_o[FLAG_Z]  = (result_o == '0) && !bad;
    end

endmodule

// File: rtl/arith_result_stage.sv
// Registered output stage behind the combinational operation units.
// Sanitised results and flags are held in an output register backed by a
// one-entry skid register, so o_ready is a pure register and upstream can
// still stream one operation per cycle.
// Optional build macro: ARITH_RESULT_ERR_CNT_EN adds i_cnt_clr/o_err_cnt and
// a saturating count of pushes that carried an error or overflow bit.
module arith_result_stage
    import arith_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rsn,
    input  logic [BITS-1:0]      i_result,
    input  logic                 i_error,
    input  logic                 i_overflow,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [BITS-1:0]      o_result,
    output logic [3:0]           o_flags,
    output logic                 o_valid,
`ifdef ARITH_RESULT_ERR_CNT_EN
    input  logic                 i_cnt_clr,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
`endif
    input  logic                 i_ready
);

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic [BITS-1:0] out_res_q, out_res_d;
    flags_t          out_flags_q, out_flags_d;
    logic [BITS-1:0] skid_res_q, skid_res_d;
    flags_t          skid_flags_q, skid_flags_d;

    logic [BITS-1:0] cap_res;
    flags_t          cap_flags;
    logic            push;
    logic            pop;

    arith_flag_gen #(
        .BITS (BITS)
    ) u_flag_gen (
        .result_i   (i_result),
        .error_i    (i_error),
        .overflow_i (i_overflow),
        .result_o   (cap_res),
        .flags_o    (cap_flags)
    );

    assign push = i_valid && ready_q;
    assign pop  = (state_q != EMPTY) && i_ready;

    // Buffer FSM: decide where an accepted entry lands and what moves forward on a pop.
    always_comb begin
        state_d      = state_q;
        out_res_d    = out_res_q;
        out_flags_d  = out_flags_q;
        skid_res_d   = skid_res_q;
        skid_flags_d = skid_flags_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    out_res_d   = cap_res;
                    out_flags_d = cap_flags;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    skid_res_d   = cap_res;
                    skid_flags_d = cap_flags;
                    state_d      = TWO;
                end else if (push && pop) begin
                    out_res_d   = cap_res;
                    out_flags_d = cap_flags;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // ready_q is low here, so only the drain path exists.
                if (pop) begin
                    out_res_d   = skid_res_q;
                    out_flags_d = skid_flags_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != TWO);
    end

    // State, ready and the visible output register; reset clears them all so no stale entry leaks out.
    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            state_q     <= EMPTY;
            ready_q     <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            out_res_q   <= out_res_d;
            out_flags_q <= out_flags_d;
        end
    end

    // Skid register holds data only; it is never observed unless state says it is full.
    always_ff @(posedge i_clk) begin
        skid_res_q   <= skid_res_d;
        skid_flags_q <= skid_flags_d;
    end

    assign o_valid  = (state_q != EMPTY);
    assign o_ready  = ready_q;
    assign o_result = out_res_q;
    assign o_flags  = out_flags_q;

`ifdef ARITH_RESULT_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Count faulty pushes, sticking at full scale; a clear overrides a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_cnt_clr) begin
            err_cnt_d = '0;
        end else if (push && (i_error || i_overflow)) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    // Error counter register.
    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_arith_result_stage.sv
// Bench for arith_result_stage: a reference model fills a scoreboard queue on
// every accepted push; scenario tasks compare the DUT outputs against the
// queue head and against literal expected values.
module tb_arith_result_stage;

    localparam int BITS = 32;

    logic            clk;
    logic            i_rsn;
    logic [BITS-1:0] i_result;
    logic            i_error;
    logic            i_overflow;
    logic            i_valid;
    logic            o_ready;
    logic [BITS-1:0] o_result;
    logic [3:0]      o_flags;
    logic            o_valid;
    logic            i_ready;
`ifdef ARITH_RESULT_ERR_CNT_EN
    logic            i_cnt_clr;
    logic [7:0]      o_err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [BITS+3:0] sb[$];

    arith_result_stage #(
        .BITS (BITS)
    ) dut (
        .i_clk      (clk),
        .i_rsn      (i_rsn),
        .i_result   (i_result),
        .i_error    (i_error),
        .i_overflow (i_overflow),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_result   (o_result),
        .o_flags    (o_flags),
        .o_valid    (o_valid),
`ifdef ARITH_RESULT_ERR_CNT_EN
        .i_cnt_clr  (i_cnt_clr),
        .o_err_cnt  (o_err_cnt),
`endif
        .i_ready    (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sanitised result concatenated with {E,V,N,Z}.
    function automatic logic [BITS+3:0] model(input logic [BITS-1:0] r, input logic e, input logic v);
        logic [BITS-1:0] s;
        logic            z;
        if (e || v) s = '0;
        else        s = r;
        z = (s == '0) && !e && !v;
        return {s, e, v, s[BITS-1], z};
    endfunction

    // Scoreboard upkeep at each active edge.
    always @(posedge clk) begin
        if (!i_rsn) begin
            sb.delete();
        end else begin
            if (o_valid === 1'b1 && i_ready && sb.size() != 0) void'(sb.pop_front());
            if (i_valid && o_ready === 1'b1) sb.push_back(model(i_result, i_error, i_overflow));
        end
    end

    // Apply inputs just after a falling edge and return at the next falling edge.
    task automatic drv(input logic v, input logic [BITS-1:0] r, input logic e,
                       input logic o, input logic rdy);
        i_valid    = v;
        i_result   = r;
        i_error    = e;
        i_overflow = o;
        i_ready    = rdy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        i_rsn = 1'b0;
        drv(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_valid !== 1'b0 || o_result !== '0 || o_flags !== 4'b0000 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b result=%h flags=%b ready=%b required 0/0/0/0",
                     o_valid, o_result, o_flags, o_ready);
        end
`ifdef ARITH_RESULT_ERR_CNT_EN
        n_checks++;
        if (o_err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_err_cnt: got %0d required 0", o_err_cnt);
        end
`endif
        i_rsn = 1'b1;
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b required ready=1 valid=0", o_ready, o_valid);
        end
    endtask

    task automatic test_basic();
        drv(1'b1, 32'h0000_00F0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 32'h0000_00F0 || o_flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL basic_out: valid=%b result=%h flags=%b required 1/000000f0/0000",
                     o_valid, o_result, o_flags);
        end
        n_checks++;
        if (sb.size() != 1 || sb[0] !== {o_result, o_flags}) begin
            n_fail++;
            $display("FAIL basic_sb: queued=%0d dut=%h required one entry equal to dut",
                     sb.size(), {o_result, o_flags});
        end
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: valid=%b required 0", o_valid);
        end
    endtask

    task automatic test_flags();
        logic [BITS-1:0] r_tab[5]  = '{32'h0000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        logic            e_tab[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic            v_tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [BITS-1:0] er_tab[5] = '{32'h0000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0};
        logic [3:0]      ef_tab[5] = '{4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b1100};
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, r_tab[i], e_tab[i], v_tab[i], 1'b1);
            n_checks++;
            if (o_valid !== 1'b1 || o_result !== er_tab[i] || o_flags !== ef_tab[i]) begin
                n_fail++;
                $display("FAIL flags[%0d]: valid=%b result=%h flags=%b required 1/%h/%b",
                         i, o_valid, o_result, o_flags, er_tab[i], ef_tab[i]);
            end
            n_checks++;
            if (sb.size() != 1 || sb[0] !== {o_result, o_flags}) begin
                n_fail++;
                $display("FAIL flags_sb[%0d]: queued=%0d dut=%h required one matching entry",
                         i, sb.size(), {o_result, o_flags});
            end
        end
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        drv(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b1 || o_result !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_after_a: ready=%b valid=%b result=%h required 1/1/1", o_ready, o_valid, o_result);
        end
        drv(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_ready !== 1'b0 || o_result !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_full: ready=%b result=%h required ready=0 result=1", o_ready, o_result);
        end
        drv(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== 32'd1 || sb.size() != 2) begin
            n_fail++;
            $display("FAIL bp_hold: ready=%b valid=%b result=%h queued=%0d required 0/1/1/2",
                     o_ready, o_valid, o_result, sb.size());
        end
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== 32'd2 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: valid=%b result=%h ready=%b required 1/2/1", o_valid, o_result, o_ready);
        end
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b queued=%0d required 0/0 (third push must be dropped)",
                     o_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, BITS'(i), 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (o_valid !== 1'b1 || o_result !== BITS'(i) || o_flags !== 4'b0000 || o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream[%0d]: valid=%b result=%h flags=%b ready=%b required 1/%h/0000/1",
                         i, o_valid, o_result, o_flags, o_ready, BITS'(i));
            end
        end
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: valid=%b required 0", o_valid);
        end
    endtask

    task automatic test_reset_mid();
        drv(1'b1, 32'd9, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_ready !== 1'b0 || o_result !== 32'd9) begin
            n_fail++;
            $display("FAIL mid_full: ready=%b result=%h required 0/9", o_ready, o_result);
        end
        i_rsn = 1'b0;
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (o_valid !== 1'b0 || o_result !== '0 || o_flags !== 4'b0000 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b result=%h flags=%b ready=%b required 0/0/0/0",
                     o_valid, o_result, o_flags, o_ready);
        end
        i_rsn = 1'b1;
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release: valid=%b ready=%b required 0/1", o_valid, o_ready);
        end
    endtask

`ifdef ARITH_RESULT_ERR_CNT_EN
    task automatic test_err_cnt();
        i_cnt_clr = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            drv(1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1);
            if (i == 5 || i == 255 || i == 300) begin
                n_checks++;
                if (o_err_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
                    n_fail++;
                    $display("FAIL err_cnt[%0d]: got %0d required %0d", i, o_err_cnt, (i > 255) ? 255 : i);
                end
            end
        end
        i_cnt_clr = 1'b1;
        drv(1'b1, 32'h1, 1'b0, 1'b1, 1'b1);
        i_cnt_clr = 1'b0;
        n_checks++;
        if (o_err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL err_cnt_clr: got %0d required 0", o_err_cnt);
        end
        drv(1'b1, 32'h1, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (o_err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL err_cnt_after_clr: got %0d required 1", o_err_cnt);
        end
        drv(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        i_rsn      = 1'b0;
        i_valid    = 1'b0;
        i_result   = '0;
        i_error    = 1'b0;
        i_overflow = 1'b0;
        i_ready    = 1'b0;
`ifdef ARITH_RESULT_ERR_CNT_EN
        i_cnt_clr  = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_basic();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef ARITH_RESULT_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_result_stage.md
Name: arith_result_stage

Overview:
- Registered output stage directly downstream of the combinational operation units (shift, add, etc.) of the synchronous arithmetic unit.
- Captures each unit's result together with its error and overflow bits, sanitises undefined results, derives status flags, and presents them to the consumer through a valid/ready handshake.
- A 2-entry skid buffer lets the upstream side stream one operation per cycle without a combinational ready path.

Parameters:
- BITS, 32, width of the result vector.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rsn  input  1  synchronous, active-low reset.
- i_result  input  BITS  result from the operation unit.
- i_error  input  1  operation error bit from the unit.
- i_overflow  input  1  operation overflow bit from the unit.
- i_valid  input  1  upstream holds a valid operation.
- o_ready  output  1  stage can accept; registered, depends on state only.
- o_result  output  BITS  registered, sanitised result.
- o_flags  output  4  registered status {E,V,N,Z}.
- o_valid  output  1  o_result/o_flags hold a valid entry.
- i_ready  input  1  consumer accepts the entry.
- i_cnt_clr  input  1  clear error counter (ERR_CNT_EN only).
- o_err_cnt  output  8  saturating error/overflow count (ERR_CNT_EN only).

Behaviour:
- Reset (i_rsn=0 at an edge):
  - State goes to EMPTY.
  - o_valid=0, o_result=0, o_flags=0, o_ready=0 while i_rsn is low; o_ready=1 on the first edge with i_rsn high.
  - o_err_cnt=0.
  - Reset mid-operation drops all buffered entries; no partial output is emitted.
- Handshake:
  - push = i_valid && o_ready.
  - pop = o_valid && i_ready.
  - Once o_valid is asserted, o_result and o_flags stay stable until pop.
- Sanitisation at capture:
  - If i_error or i_overflow is set, the stored result is all zeros and i_result is ignored, since it may be undefined.
  - Otherwise the stored result is i_result.
- Flags, computed from the sanitised result at capture:
  - E = i_error.
  - V = i_overflow.
  - N = result[BITS-1].
  - Z = (result==0) && !E && !V.
  - If E and V are both set, both flags are stored; no priority is applied.
- States: EMPTY (nothing held), ONE (output register full), TWO (output register and skid register full).
  - EMPTY: push -> ONE, entry loaded into the output register.
  - ONE: push && !pop -> TWO, entry into skid; !push && pop -> EMPTY; push && pop -> ONE, new entry loaded into the output register; neither -> ONE.
  - TWO: pop -> ONE, skid entry moved to the output register; no push is possible in TWO.
- Outputs by state:
  - o_valid = (state != EMPTY).
  - o_ready = (state != TWO) && reset released.
- Latency: an entry pushed at edge k is visible on o_result/o_valid from edge k onward (1 cycle).
- Order: strictly FIFO.
- Throughput: 1 entry per cycle when i_ready is held high.

Optional Feature:
- Macro: ARITH_RESULT_ERR_CNT_EN.
- With the macro defined:
  - The ports i_cnt_clr and o_err_cnt exist.
  - o_err_cnt increments by 1 on every push where i_error or i_overflow is set, and saturates at 255.
  - i_cnt_clr=1 sets the counter to 0 at the next edge; clear wins over a simultaneous increment.
- Without the macro: neither port nor the counter register exists; all other behaviour is identical.

Decomposition:
- Shared package arith_pkg holds:
  - FLAG_E=3, FLAG_V=2, FLAG_N=1, FLAG_Z=0 bit indices;
  - the typedef flags_t (logic [3:0]);
  - typedef enum state_t {EMPTY, ONE, TWO};
  - ERR_CNT_W=8.
- One sub-module, arith_flag_gen: combinational sanitisation and flag derivation, instantiated once at the capture input.
- The FSM and both registers live in the top module.

Test Plan:
- Reset release, then push i_result=0x0000_00F0, flags clean, with i_ready=1 -> next cycle o_valid=1, o_result=0x0000_00F0, o_flags=4'b0000; following cycle o_valid=0.
- Push i_result=0, no error -> o_flags=4'b0001 (Z). Push i_result=0x8000_0000 -> o_flags=4'b0010 (N).
- Push i_result=0xDEAD_BEEF with i_error=1 -> o_result=0, o_flags=4'b1000. Repeat with i_overflow=1 -> o_flags=4'b0100, Z=0.
- Backpressure, i_ready=0, pushes A=1, B=2:
  - o_ready falls after B;
  - a third push C=3 is not accepted;
  - raise i_ready -> outputs 1 then 2 in order, o_ready returns to 1.
- Streaming: 8 consecutive pushes 1..8 with i_ready=1 -> 8 consecutive o_valid cycles, values 1..8, no bubbles. Assert i_rsn=0 while in TWO -> next edge o_valid=0, o_result=0.
- ARITH_RESULT_ERR_CNT_EN build:
  - 300 error pushes -> o_err_cnt=255.
  - i_cnt_clr together with an error push -> o_err_cnt=0.
